// File: rtl/sentinel_pkg.sv
// Shared types and constants for the Sentinel perimeter lock controller.
package sentinel_pkg;

  // Session states of the gatekeeper.
  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } gate_state_t;

  // 7-segment codes {dp,g,f,e,d,c,b,a}, active low.
  localparam logic [7:0] SEG_LOCKED   = 8'hC7;  // 'L'
  localparam logic [7:0] SEG_VERIFIED = 8'hC1;  // 'U'
  localparam logic [7:0] SEG_LOCKOUT  = 8'h86;  // 'E'
  localparam logic [7:0] SEG_OFF      = 8'hFF;  // blank

  // Status array patterns.
  localparam logic [7:0] STAT_UNLOCK  = 8'hFF;
  localparam logic [7:0] STAT_LOCKOUT = 8'hAA;
  localparam logic [7:0] STAT_OFF     = 8'h00;

  // Width of the failed-attempt counter.
  localparam int unsigned FAIL_W = 32'd3;

  // Timer width large enough to hold the longer window minus one; never below 1 bit.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
    int unsigned longest;
    int unsigned w;
    longest = (a > b) ? a : b;
    w       = $clog2(longest);
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/sentinel_timer.sv
// Loadable down counter shared by the unlock window and the lockout period.
// A load always wins over a decrement, and the count never wraps below zero.
module sentinel_timer
  import sentinel_pkg::*;
#(
  parameter int unsigned WIDTH = 32'd6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: load, saturating decrement, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != {WIDTH{1'b0}})) begin
      cnt_d = cnt_q - WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {WIDTH{1'b0}});

endmodule

// File: rtl/sentinel_gatekeeper.sv
// Sentinel perimeter lock sequencer: turns DIP key submits into an
// authorization session with a timed unlock window, failed-attempt counting
// and a timed lockout. Drives the 7-segment display and status array.
module sentinel_gatekeeper
  import sentinel_pkg::*;
#(
  parameter logic [7:0]  KEY            = 8'hB6,
  parameter int unsigned MAX_FAILS      = 32'd3,
  parameter int unsigned UNLOCK_CYCLES  = 32'd16,
  parameter int unsigned LOCKOUT_CYCLES = 32'd64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] key_in,
  input  logic       submit,
  output logic [7:0] seg_out,
  output logic [7:0] status,
  output logic       unlocked,
  output logic       lockout
);

  localparam int unsigned       TW           = timer_width(UNLOCK_CYCLES, LOCKOUT_CYCLES);
  localparam logic [TW-1:0]     UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 32'd1);
  localparam logic [TW-1:0]     LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 32'd1);
  localparam logic [FAIL_W-1:0] FAIL_LIMIT   = FAIL_W'(MAX_FAILS);
  localparam logic [FAIL_W-1:0] FAIL_SAT     = {FAIL_W{1'b1}};

  gate_state_t       state_q;
  gate_state_t       state_d;
  logic [FAIL_W-1:0] fail_cnt_q;
  logic [FAIL_W-1:0] fail_cnt_d;
  logic [FAIL_W-1:0] fail_next_s;
  logic              submit_q;
  logic              submit_d;
  logic              submit_edge_s;
  logic              key_match_s;
  logic              tmr_load_s;
  logic [TW-1:0]     tmr_load_val_s;
  logic              tmr_en_s;
  logic              tmr_zero_s;

  // Button history follows the pin even while disabled, so a press held
  // across re-enable is not seen as a new edge.
  assign submit_d      = submit;
  assign submit_edge_s = submit & ~submit_q & ena;
  assign key_match_s   = (key_in == KEY);

  // Saturating increment of the failed-attempt count.
  always_comb begin
    if (fail_cnt_q == FAIL_SAT) begin
      fail_next_s = fail_cnt_q;
    end else begin
      fail_next_s = fail_cnt_q + FAIL_W'(1);
    end
  end

  // Next-state, fail counter and timer control; everything holds while ena is low.
  always_comb begin
    state_d        = state_q;
    fail_cnt_d     = fail_cnt_q;
    tmr_load_s     = 1'b0;
    tmr_load_val_s = {TW{1'b0}};
    tmr_en_s       = 1'b0;
    if (ena) begin
      case (state_q)
        ST_LOCKED: begin
          if (submit_edge_s && key_match_s) begin
            state_d        = ST_UNLOCKED;
            fail_cnt_d     = {FAIL_W{1'b0}};
            tmr_load_s     = 1'b1;
            tmr_load_val_s = UNLOCK_LOAD;
          end else if (submit_edge_s) begin
            if (fail_next_s == FAIL_LIMIT) begin
              state_d        = ST_LOCKOUT;
              fail_cnt_d     = FAIL_LIMIT;
              tmr_load_s     = 1'b1;
              tmr_load_val_s = LOCKOUT_LOAD;
            end else begin
              fail_cnt_d = fail_next_s;
            end
          end else begin
            state_d = ST_LOCKED;
          end
        end
        ST_UNLOCKED: begin
          // A matching resubmit restarts the window even on its last cycle.
          if (submit_edge_s && key_match_s) begin
            tmr_load_s     = 1'b1;
            tmr_load_val_s = UNLOCK_LOAD;
          end else if (submit_edge_s) begin
            state_d = ST_LOCKED;
          end else if (tmr_zero_s) begin
            state_d = ST_LOCKED;
          end else begin
            tmr_en_s = 1'b1;
          end
        end
        ST_LOCKOUT: begin
          // Submits are deliberately ignored for the whole lockout.
          if (tmr_zero_s) begin
            state_d    = ST_LOCKED;
            fail_cnt_d = {FAIL_W{1'b0}};
          end else begin
            tmr_en_s = 1'b1;
          end
        end
        default: begin
          state_d    = ST_LOCKED;
          fail_cnt_d = {FAIL_W{1'b0}};
        end
      endcase
    end else begin
      state_d    = state_q;
      fail_cnt_d = fail_cnt_q;
    end
  end

  // State, fail counter and button history registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_LOCKED;
      fail_cnt_q <= {FAIL_W{1'b0}};
      submit_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fail_cnt_q <= fail_cnt_d;
      submit_q   <= submit_d;
    end
  end

  sentinel_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .load_val (tmr_load_val_s),
    .en       (tmr_en_s),
    .zero     (tmr_zero_s)
  );

  // Moore decode of display and status from the state registers, blanked when disabled.
  always_comb begin
    seg_out  = SEG_OFF;
    status   = STAT_OFF;
    unlocked = 1'b0;
    lockout  = 1'b0;
    if (ena) begin
      case (state_q)
        ST_LOCKED: begin
          seg_out = SEG_LOCKED;
          status  = {5'b00000, fail_cnt_q};
        end
        ST_UNLOCKED: begin
          seg_out  = SEG_VERIFIED;
          status   = STAT_UNLOCK;
          unlocked = 1'b1;
        end
        ST_LOCKOUT: begin
          seg_out = SEG_LOCKOUT;
          status  = STAT_LOCKOUT;
          lockout = 1'b1;
        end
        default: begin
          seg_out = SEG_LOCKED;
          status  = STAT_OFF;
        end
      endcase
    end else begin
      seg_out = SEG_OFF;
      status  = STAT_OFF;
    end
  end

endmodule
